uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// Imported by the picker and the arbiter top.
package uart_arb_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping past N_REQ-1 back to 0.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         pick,
  output logic [$clog2(N_REQ)-1:0] pick_idx,
  output logic                     pick_valid
);

  localparam int PW = $clog2(N_REQ);

  logic [PW:0] slot;

  // One extra bit on slot so ptr+k can be wrapped for non-power-of-two N_REQ.
  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    slot       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      slot = {1'b0, ptr} + (PW+1)'(k);
      if (slot >= (PW+1)'(N_REQ)) begin
        slot = slot - (PW+1)'(N_REQ);
      end
      if (!pick_valid && req[slot[PW-1:0]]) begin
        pick_valid              = 1'b1;
        pick[slot[PW-1:0]]      = 1'b1;
        pick_idx                = slot[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters with
// round-robin grants, message-granular ownership and a per-grant burst cap.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic                      busy
);

  localparam int         PW        = $clog2(N_REQ);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]        count_q, count_d;
  logic              last_q, last_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [N_REQ-1:0]  req_ack_q, req_ack_d;

  logic [N_REQ-1:0]  pick;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;
  logic [PW-1:0]     ptr_after_owner;
  logic [BYTE_W-1:0] lane [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req        (req),
    .ptr        (rr_ptr_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign ptr_after_owner = (gidx_q == PW'(N_REQ-1)) ? '0 : gidx_q + PW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    req_ack_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ST_LOAD;
        end else begin
          grant_d = '0;
        end
      end
      ST_LOAD: begin
        if (req[gidx_q]) begin
          tx_data_d  = lane[gidx_q];
          tx_start_d = 1'b1;
          req_ack_d  = grant_q;
          last_d     = req_last[gidx_q];
          count_d    = count_q + 8'd1;
          state_d    = ST_WAIT;
        end else begin
          // Owner walked away mid-message; its burst allowance goes with it.
          grant_d  = '0;
          count_d  = '0;
          rr_ptr_d = ptr_after_owner;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A done pulse coincident with our own start belongs to a stale frame.
        if (tx_done && !tx_start_q) begin
          if (last_q || count_q >= BURST_MAX) begin
            grant_d  = '0;
            count_d  = '0;
            rr_ptr_d = ptr_after_owner;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      req_ack_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      req_ack_q  <= req_ack_d;
    end
  end

  assign grant    = grant_q;
  assign req_ack  = req_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a transmitter model and a
// message-level round-robin model predicting the frame sequence.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_done;
  logic           busy;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester byte queues: bit 8 is the last-of-message flag.
  logic [8:0] rmem [N][64];
  int rhead [N];
  int rtail [N];
  logic [N-1:0] en;

  int cyc, tmr, last_done, delay_fixed;
  bit rand_delay, early_arm;
  int log_req[$], log_data[$], log_gap[$];
  int exp_req[$], exp_data[$], exp_gap[$];

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      if (rhead[i] < rtail[i]) begin
        req[i]          = en[i];
        req_data[8*i+:8] = rmem[i][rhead[i]][7:0];
        req_last[i]     = rmem[i][rhead[i]][8];
      end else begin
        req[i]          = 1'b0;
        req_data[8*i+:8] = 8'h00;
        req_last[i]     = 1'b0;
      end
    end
  endfunction

  function automatic void push(input int i, input logic [7:0] d, input logic last);
    rmem[i][rtail[i]] = {last, d};
    rtail[i]++;
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (rhead[i] < rtail[i]) e = 1'b0;
    return e;
  endfunction

  function automatic void clear_log();
    log_req.delete(); log_data.delete(); log_gap.delete();
    exp_req.delete(); exp_data.delete(); exp_gap.delete();
    last_done = -1;
  endfunction

  function automatic void expect_frame(input int r, input int d, input int g);
    exp_req.push_back(r); exp_data.push_back(d); exp_gap.push_back(g);
  endfunction

  // Message-level model: pick from ptr with wrap, serve until last or cap.
  function automatic int model_run(input int ptr0);
    int h [N];
    int ptr, g, cnt, j;
    bit first, done;
    ptr = ptr0; first = 1'b1;
    for (int i = 0; i < N; i++) h[i] = rhead[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (g < 0 && h[j] < rtail[j]) g = j;
      end
      if (g < 0) break;
      cnt = 0;
      do begin
        expect_frame(g, int'(rmem[g][h[g]][7:0]), first ? -1 : (cnt == 0 ? 3 : 2));
        first = 1'b0;
        done = rmem[g][h[g]][8];
        h[g]++;
        cnt++;
      end while (!done && cnt < MAXB && h[g] < rtail[g]);
      ptr = (g + 1) % N;
    end
    return ptr;
  endfunction

  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    tx_done = 1'b0;
    check_eq("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    if (tx_start) check_eq("ack_eq_grant", 32'(req_ack), 32'(grant));
    else          check_eq("ack_without_start", 32'(req_ack), 32'd0);
    if (tmr > 0) begin
      tmr--;
      if (tmr == 0) begin
        tx_done   = 1'b1;
        last_done = cyc;
        tmr       = -1;
      end
    end
    if (tx_start) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
      log_req.push_back(idx);
      log_data.push_back(int'(tx_data));
      log_gap.push_back(last_done >= 0 ? cyc - last_done : -1);
      $display("frame cycle %0d requester %0d data %02h", cyc, idx, tx_data);
      tmr = rand_delay ? int'($urandom_range(1, 6)) : delay_fixed;
      if (early_arm) begin
        tx_done   = 1'b1;
        early_arm = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (req_ack[i] && rhead[i] < rtail[i]) rhead[i]++;
    drive();
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    while (!(all_empty() && !busy && tmr < 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic compare_frames(input string tag);
    int m;
    check_eq({tag, "_count"}, 32'(log_req.size()), 32'(exp_req.size()));
    m = (log_req.size() < exp_req.size()) ? log_req.size() : exp_req.size();
    for (int k = 0; k < m; k++) begin
      check_eq({tag, "_req"}, 32'(log_req[k]), 32'(exp_req[k]));
      check_eq({tag, "_data"}, 32'(log_data[k]), 32'(exp_data[k]));
      if (exp_gap[k] >= 0) check_eq({tag, "_gap"}, 32'(log_gap[k]), 32'(exp_gap[k]));
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_start_seen"}, 32'(tx_start), 32'd1);
  endtask

  task automatic hard_reset();
    reset = 1'b0;
    tmr = -1; tx_done = 1'b0; early_arm = 1'b0;
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ptr;
    reset = 1'b1; tx_done = 1'b0; en = '1; cyc = 0; tmr = -1; last_done = -1;
    delay_fixed = 3; rand_delay = 1'b0; early_arm = 1'b0;
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; end
    drive();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_req_ack", 32'(req_ack), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_grant", 32'(grant), 32'd0);

    // Rotation from ptr 0 with one-byte messages.
    clear_log();
    push(0, 8'h10, 1); push(0, 8'h11, 1); push(1, 8'h20, 1); push(2, 8'h30, 1); push(3, 8'h40, 1);
    drive();
    run_idle(400, "rot");
    expect_frame(0, 'h10, -1); expect_frame(1, 'h20, 3); expect_frame(2, 'h30, 3);
    expect_frame(3, 'h40, 3); expect_frame(0, 'h11, 3);
    compare_frames("rot");

    // Two-byte message from requester 2, done 20 cycles after each start.
    clear_log();
    delay_fixed = 20;
    push(2, 8'h41, 0); push(2, 8'h42, 1);
    drive();
    tick();
    check_eq("lat_grant", 32'(grant), 32'b0100);
    check_eq("lat_no_start", 32'(tx_start), 32'd0);
    tick();
    check_eq("lat_start", 32'(tx_start), 32'd1);
    check_eq("lat_data", 32'(tx_data), 32'h41);
    check_eq("lat_ack", 32'(req_ack), 32'b0100);
    run_idle(400, "single");
    expect_frame(2, 'h41, -1); expect_frame(2, 'h42, 2);
    compare_frames("single");
    check_eq("single_grant_after", 32'(grant), 32'd0);

    // Pointer must now sit at 3: requester 3 wins over 0.
    clear_log();
    delay_fixed = 3;
    push(0, 8'h50, 1); push(3, 8'h53, 1);
    drive();
    run_idle(400, "ptr3");
    expect_frame(3, 'h53, -1); expect_frame(0, 'h50, 3);
    compare_frames("ptr3");

    // Burst cap of 3 on a 5-byte message from requester 1, requester 0 waiting.
    clear_log();
    for (int b = 0; b < 5; b++) push(1, 8'(8'h60 + b), b == 4);
    push(0, 8'h70, 1);
    drive();
    run_idle(600, "burst");
    expect_frame(1, 'h60, -1); expect_frame(1, 'h61, 2); expect_frame(1, 'h62, 2);
    expect_frame(0, 'h70, 3);  expect_frame(1, 'h63, 3); expect_frame(1, 'h64, 2);
    compare_frames("burst");

    // Requester 3 drops req as its grant rises.
    clear_log();
    push(3, 8'h80, 1);
    drive();
    tick();
    check_eq("abn_grant", 32'(grant), 32'b1000);
    en[3] = 1'b0;
    drive();
    tick();
    check_eq("abn_grant_cleared", 32'(grant), 32'd0);
    check_eq("abn_no_start", 32'(tx_start), 32'd0);
    check_eq("abn_idle", 32'(busy), 32'd0);
    en[3] = 1'b1;
    push(0, 8'h81, 1);
    drive();
    run_idle(400, "abn");
    expect_frame(0, 'h81, -1); expect_frame(3, 'h80, 3);
    compare_frames("abn");

    // Done pulse coincident with tx_start must be ignored.
    clear_log();
    delay_fixed = 4;
    push(1, 8'h90, 0); push(1, 8'h91, 1);
    early_arm = 1'b1;
    drive();
    wait_start("early");
    repeat (3) tick();
    check_eq("early_still_busy", 32'(busy), 32'd1);
    check_eq("early_no_restart", 32'(log_req.size()), 32'd1);
    run_idle(400, "early");
    expect_frame(1, 'h90, -1); expect_frame(1, 'h91, 2);
    compare_frames("early");

    // Reset during a frame from requester 2 (pointer at 2).
    clear_log();
    push(2, 8'hA5, 1);
    drive();
    wait_start("rmid");
    #2 reset = 1'b0;
    #1;
    check_eq("rmid_tx_start", 32'(tx_start), 32'd0);
    check_eq("rmid_req_ack", 32'(req_ack), 32'd0);
    check_eq("rmid_grant", 32'(grant), 32'd0);
    check_eq("rmid_tx_data", 32'(tx_data), 32'd0);
    check_eq("rmid_busy", 32'(busy), 32'd0);
    hard_reset();
    clear_log();
    push(1, 8'hB1, 1); push(2, 8'hB2, 1);
    drive();
    tick();
    check_eq("rmid_regrant", 32'(grant), 32'b0010);
    run_idle(400, "rmid");
    expect_frame(1, 'hB1, -1); expect_frame(2, 'hB2, 3);
    compare_frames("rmid");

    // Randomized messages, random transmitter latency, pointer carried across rounds.
    hard_reset();
    rand_delay = 1'b1;
    ptr = 0;
    for (int round = 0; round < 3; round++) begin
      int nm, len;
      clear_log();
      for (int i = 0; i < N; i++) begin
        nm = int'($urandom_range(0, 3));
        for (int m = 0; m < nm; m++) begin
          len = int'($urandom_range(1, 5));
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
      end
      ptr = model_run(ptr);
      drive();
      run_idle(5000, "rand");
      compare_frames("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
